// File: rtl/ysyx_25040105_sram_slave_if.sv
// Request/response channel between a core-side master (LSU/IFU) and the
// SRAM slave. Both directions use valid/ready handshakes.
interface ysyx_25040105_sram_slave_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25040105_sram_slave.sv
// Fixed-latency SRAM responder for core load/store/fetch traffic.
// One request is in flight at a time. The response appears LATENCY cycles after
// the accept edge and is held until the master takes it.
// Optional build macro SRAM_MISALIGN_CHK_EN: when defined, a request whose
// addr[1:0] is not 2'b00 returns an access fault instead of touching the array.
module ysyx_25040105_sram_slave #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst,   // synchronous, active-low
    ysyx_25040105_sram_slave_if.slave     bus
);
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Captured request; only meaningful while BUSY, so it carries no reset.
    logic [31:0] addr_q;
    logic        wen_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem [DEPTH];

    // Address decode on the captured request.
    logic [31:0]      off;
    logic             in_range;
    logic             fault;
    logic [IDX_W-1:0] idx;
    logic             commit;

    assign off      = addr_q - BASE;
    assign in_range = (addr_q >= BASE) && (off < SPAN);
    assign idx      = off[IDX_W+1:2];
`ifdef SRAM_MISALIGN_CHK_EN
    assign fault    = !in_range || (addr_q[1:0] != 2'b00);
`else
    assign fault    = !in_range;
`endif
    // The access takes effect on the last BUSY edge, i.e. when the countdown is spent.
    assign commit   = (state_q == S_BUSY) && (cnt_q == '0);

    // Ready only while idle and out of reset; no same-cycle turnaround from RESP.
    assign bus.req_ready = (state_q == S_IDLE) && rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Byte-lane write into the array; gated by rst so a reset during BUSY drops the write.
    always_ff @(posedge clk) begin
        if (rst && commit && !fault && wen_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wen_q   <= bus.req_wen;
                        wdata_q <= bus.req_wdata;
                        wmask_q <= bus.req_wmask;
                        cnt_q   <= CNT_START;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                        if (fault) begin
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end else if (wen_q) begin
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            rsp_rdata_q <= mem[idx];
                            rsp_err_q   <= 1'b0;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040105_sram_slave.sv
// Self-checking bench for the SRAM slave: directed scenarios plus randomized
// traffic compared against a word/byte-level memory model.
module tb_ysyx_25040105_sram_slave;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Reference model: word contents plus per-byte "has been written" flags.
    logic [31:0] mdl      [DEPTH];
    logic [3:0]  mdl_known[DEPTH];

    ysyx_25040105_sram_slave_if bus ();

    ysyx_25040105_sram_slave #(
        .DEPTH  (DEPTH),
        .LATENCY(LAT),
        .BASE   (BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_fault(input logic [31:0] a);
        longint unsigned ua;
        ua = longint'(a);
        if (ua < 64'h8000_0000 || ua >= 64'h8000_0000 + 64'(4 * DEPTH)) return 1'b1;
`ifdef SRAM_MISALIGN_CHK_EN
        if (a[1:0] != 2'b00) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One full transaction: wait for ready, issue, measure latency, apply
    // backpressure for 'hold' cycles, complete the handshake, check vs model.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] m, input int hold,
                        output logic [31:0] rd, output logic er);
        int          n;
        int          ix;
        bit          ef;
        logic [31:0] exp_d;
        logic [31:0] km;
        logic [31:0] v0;
        logic        e0;
        ef    = model_fault(a);
        ix    = ef ? 0 : model_idx(a);
        exp_d = 32'h0;
        km    = 32'hFFFF_FFFF;
        if (!ef && !w) begin
            exp_d = mdl[ix];
            for (int i = 0; i < 4; i++) km[8*i +: 8] = {8{mdl_known[ix][i]}};
        end

        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready);
        end

        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        bus.req_wmask = m;
        @(posedge clk); #1;
        // Scramble master inputs: they must be ignored while not idle.
        bus.req_valid = $urandom_range(0, 1);
        bus.req_addr  = $urandom();
        bus.req_wen   = $urandom_range(0, 1);
        bus.req_wdata = $urandom();
        bus.req_wmask = 4'($urandom());
        bus.rsp_ready = 1'b1;   // ignored outside RESP

        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: req_ready=%b required 0", bus.req_ready);
        end

        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < LAT + 10) begin
            @(posedge clk); #1; n++;
        end
        bus.rsp_ready = (hold == 0);
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d", n, LAT);
        end

        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        checks++;
        if (er !== ef || ((rd & km) !== (exp_d & km))) begin
            errors++;
            $display("FAIL rsp_data addr=%h: rdata=%h err=%b required rdata=%h (mask %h) err=%b",
                     a, rd, er, exp_d, km, ef);
        end
        if (!ef && w) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    mdl[ix][8*i +: 8] = d[8*i +: 8];
                    mdl_known[ix][i]  = 1'b1;
                end
            end
        end

        v0 = bus.rsp_rdata;
        e0 = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== v0 || bus.rsp_err !== e0 ||
                bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: valid=%b rdata=%h err=%b req_ready=%b required 1/%h/%b/0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready, v0, e0);
            end
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_done: rsp_valid=%b req_ready=%b required 0/1",
                     bus.rsp_valid, bus.req_ready);
        end
        $display("xact %s addr=%h wdata=%h mask=%h hold=%0d -> rdata=%h err=%b lat=%0d",
                 w ? "WR" : "RD", a, d, m, hold, rd, er, n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 ||
            bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b rdata=%h err=%b req_ready=%b required 0/0/0/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b rsp_valid=%b required 1/0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic        er;
        xact(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, rd, er);
        xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL full_word_read: rdata=%h err=%b required DEADBEEF/0", rd, er);
        end
        xact(32'h8000_0010, 1'b1, 32'h0000_AB00, 4'b0010, 1, rd, er);
        xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'hDEAD_ABEF) begin
            errors++;
            $display("FAIL byte_mask_read: rdata=%h required DEADABEF", rd);
        end
        xact(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, rd, er);
        xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'hDEAD_ABEF || er !== 1'b0) begin
            errors++;
            $display("FAIL zero_mask: rdata=%h err=%b required DEADABEF/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, 5, rd, er);
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic        er;
        xact(32'h8000_0000, 1'b1, 32'h1111_2222, 4'hF, 0, rd, er);
        xact(32'h8000_0FFC, 1'b1, 32'h3333_4444, 4'hF, 0, rd, er);
        xact(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL below_base: rdata=%h err=%b required 0/1", rd, er);
        end
        xact(32'h8000_1000, 1'b1, 32'h0000_0001, 4'hF, 2, rd, er);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL above_top: rdata=%h err=%b required 0/1", rd, er);
        end
        xact(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'h1111_2222) begin
            errors++;
            $display("FAIL word0_intact: rdata=%h required 11112222", rd);
        end
        xact(32'h8000_0FFC, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'h3333_4444 || er !== 1'b0) begin
            errors++;
            $display("FAIL last_word_intact: rdata=%h err=%b required 33334444/0", rd, er);
        end
    endtask

    task automatic test_reset_busy();
        logic [31:0] rd;
        logic        er;
        xact(32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 0, rd, er);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0020;
        bus.req_wen   = 1'b1;
        bus.req_wdata = 32'h1234_5678;
        bus.req_wmask = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_reset: rsp_valid=%b req_ready=%b required 0/0",
                     bus.rsp_valid, bus.req_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL busy_reset_quiet cycle %0d: rsp_valid=%b required 0", i, bus.rsp_valid);
            end
        end
        xact(32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL dropped_write: rdata=%h required CAFEF00D", rd);
        end
    endtask

    task automatic test_reset_resp();
        int n;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h8000_0020;
        bus.req_wen   = 1'b0;
        bus.req_wmask = 4'h0;
        bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < LAT + 10) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_reset_setup: rsp_valid=%b required 1", bus.rsp_valid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL resp_reset: valid=%b err=%b rdata=%h required 0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_reset_release: req_ready=%b rsp_valid=%b required 1/0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        xact(32'h8000_0012, 1'b0, 32'h0, 4'h0, 0, rd, er);
        checks++;
`ifdef SRAM_MISALIGN_CHK_EN
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL misalign_read: rdata=%h err=%b required 0/1", rd, er);
        end
`else
        if (er !== 1'b0 || rd !== 32'hDEAD_ABEF) begin
            errors++;
            $display("FAIL misalign_read: rdata=%h err=%b required DEADABEF/0", rd, er);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic        er;
        logic [31:0] a;
        int          r;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            else             a = BASE + 32'(4 * $urandom_range(0, 15)) +
                                 ((r == 2) ? 32'($urandom_range(1, 3)) : 32'h0);
            xact(a, 1'($urandom_range(0, 1)), $urandom(), 4'($urandom()),
                 $urandom_range(0, 3), rd, er);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wen   = 1'b0;
        bus.req_wdata = 32'h0;
        bus.req_wmask = 4'h0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mdl[i]       = 32'h0;
            mdl_known[i] = 4'h0;
        end
        test_reset();
        test_write_read();
        test_backpressure();
        test_faults();
        test_reset_busy();
        test_reset_resp();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
